// File: rtl/duck_flight_ctrl.sv
// duck_flight_ctrl
//   Duck motion generator. Spawns a duck at a pseudo-random ground position
//   on a rising edge of hunt_start, flies it on a bouncing diagonal path,
//   drops it when the game reports a kill and lets it escape off the top of
//   the screen after ESCAPE_TICKS movement ticks.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   hunt_start   in   level, high while the game is hunting
//   duck_killed  in   level, high after a hit
//   duck_xpos    out  [11:0] sprite left edge
//   duck_ypos    out  [11:0] sprite top edge
//   duck_dir     out  [1:0]  bit0 = moving right, bit1 = moving up
//   duck_visible out  sprite enabled
//   duck_falling out  falling sprite select
//   duck_escaped out  one-cycle pulse when the duck leaves the top edge
module duck_flight_ctrl #(
  parameter int          H_RES        = 1024,
  parameter int          DUCK_WIDTH   = 96,
  parameter int          DUCK_HEIGHT  = 60,
  parameter int          GROUND_Y     = 600,
  parameter int          MOVE_DIV     = 650_000,
  parameter int          FLY_STEP     = 2,
  parameter int          FALL_STEP    = 4,
  parameter int          ESCAPE_TICKS = 800,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hunt_start,
  input  logic        duck_killed,
  output logic [11:0] duck_xpos,
  output logic [11:0] duck_ypos,
  output logic [1:0]  duck_dir,
  output logic        duck_visible,
  output logic        duck_falling,
  output logic        duck_escaped
);

  localparam int XMAX = H_RES - DUCK_WIDTH;
  localparam int YMAX = GROUND_Y - DUCK_HEIGHT;
  localparam int TW   = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int EW   = $clog2(ESCAPE_TICKS + 1);

  localparam logic signed [12:0] FLY_S    = 13'(FLY_STEP);
  localparam logic signed [12:0] FALL_S   = 13'(FALL_STEP);
  localparam logic signed [12:0] XMAX_S   = 13'(XMAX);
  localparam logic signed [12:0] YMAX_S   = 13'(YMAX);
  localparam logic signed [12:0] GROUND_S = 13'(GROUND_Y);

  typedef enum logic [1:0] {S_HIDDEN, S_SPAWN, S_FLYING, S_FALLING} state_t;

  state_t          state_q, state_d;
  logic [11:0]     x_q, x_d, y_q, y_d;
  logic [1:0]      dir_q, dir_d;
  logic            vis_q, vis_d, fall_q, fall_d, escaped_q, escaped_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [EW-1:0]   esc_cnt_q, esc_cnt_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic            hunt_prev_q, hunt_prev_d;

  logic            tick, escaping;
  logic [11:0]     spawn_r;
  logic signed [12:0] nx, ny_fly, ny_fall;

  // Escape counter saturates so a long flight never wraps back below the limit.
  function automatic logic [EW-1:0] sat_inc(input logic [EW-1:0] v);
    return (v == EW'(ESCAPE_TICKS)) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    dir_d       = dir_q;
    esc_cnt_d   = esc_cnt_q;
    escaped_d   = 1'b0;
    hunt_prev_d = hunt_start;

    tick       = (tick_cnt_q == TW'(MOVE_DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // Candidate positions in 13-bit signed so a step past 0 shows up negative.
    escaping = (esc_cnt_q >= EW'(ESCAPE_TICKS));
    nx       = $signed({1'b0, x_q}) + (dir_q[0] ? FLY_S : -FLY_S);
    ny_fly   = $signed({1'b0, y_q}) + ((dir_q[1] || escaping) ? -FLY_S : FLY_S);
    ny_fall  = $signed({1'b0, y_q}) + FALL_S;
    spawn_r  = {2'b00, lfsr_q[9:0]};

    case (state_q)
      S_HIDDEN: begin
        if (hunt_start && !hunt_prev_q) state_d = S_SPAWN;
      end
      S_SPAWN: begin
        x_d       = (spawn_r > 12'(XMAX)) ? spawn_r - 12'(XMAX) : spawn_r;
        y_d       = 12'(YMAX);
        dir_d     = {1'b1, lfsr_q[10]};
        esc_cnt_d = '0;
        state_d   = S_FLYING;
      end
      S_FLYING: begin
        if (duck_killed) begin
          state_d = S_FALLING;
        end else if (tick && hunt_start) begin
          if (escaping && ny_fly < 13'sd0) begin
            // Leaving the top edge: no step, duck goes back under the grass.
            escaped_d = 1'b1;
            y_d       = 12'(GROUND_Y);
            state_d   = S_HIDDEN;
          end else begin
            if (nx < 13'sd0) begin
              x_d      = '0;
              dir_d[0] = ~dir_q[0];
            end else if (nx > XMAX_S) begin
              x_d      = 12'(XMAX);
              dir_d[0] = ~dir_q[0];
            end else begin
              x_d = nx[11:0];
            end
            if (escaping) begin
              y_d      = ny_fly[11:0];
              dir_d[1] = 1'b1;
            end else if (ny_fly > YMAX_S) begin
              y_d      = 12'(YMAX);
              dir_d[1] = 1'b1;
            end else if (ny_fly < 13'sd0) begin
              y_d      = '0;
              dir_d[1] = 1'b0;
            end else begin
              y_d = ny_fly[11:0];
            end
            esc_cnt_d = sat_inc(esc_cnt_q);
          end
        end
      end
      S_FALLING: begin
        if (tick) begin
          if (ny_fall >= GROUND_S) begin
            y_d     = 12'(GROUND_Y);
            state_d = S_HIDDEN;
          end else begin
            y_d = ny_fall[11:0];
          end
        end
      end
      default: state_d = S_HIDDEN;
    endcase

    vis_d  = (state_d == S_FLYING) || (state_d == S_FALLING);
    fall_d = (state_d == S_FALLING);
  end

  // Register stage: all outputs come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_HIDDEN;
      x_q         <= '0;
      y_q         <= 12'(GROUND_Y);
      dir_q       <= '0;
      vis_q       <= 1'b0;
      fall_q      <= 1'b0;
      escaped_q   <= 1'b0;
      tick_cnt_q  <= '0;
      esc_cnt_q   <= '0;
      lfsr_q      <= LFSR_SEED;
      // Treat hunt_start as already high so a level held across reset
      // does not look like a fresh rising edge.
      hunt_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dir_q       <= dir_d;
      vis_q       <= vis_d;
      fall_q      <= fall_d;
      escaped_q   <= escaped_d;
      tick_cnt_q  <= tick_cnt_d;
      esc_cnt_q   <= esc_cnt_d;
      lfsr_q      <= lfsr_d;
      hunt_prev_q <= hunt_prev_d;
    end
  end

  assign duck_xpos    = x_q;
  assign duck_ypos    = y_q;
  assign duck_dir     = dir_q;
  assign duck_visible = vis_q;
  assign duck_falling = fall_q;
  assign duck_escaped = escaped_q;

endmodule
